// File: rtl/scene_renderer_if.sv
// Pixel bus between a raster scanner and the scene renderer.
//   master: drives pix_valid/x_cord/y_cord, receives colour/colour_valid
//   slave : receives pixel coordinates, returns the resolved colour
interface scene_renderer_if #(
   parameter int unsigned COORD_W = 9
);
   logic               pix_valid;
   logic [COORD_W-1:0] x_cord;
   logic [COORD_W-1:0] y_cord;
   logic [2:0]         colour;
   logic               colour_valid;

   modport master (
      output pix_valid, x_cord, y_cord,
      input  colour, colour_valid
   );

   modport slave (
      input  pix_valid, x_cord, y_cord,
      output colour, colour_valid
   );
endinterface

// File: rtl/scene_renderer.sv
// Scene renderer: two-stage pixel colour pipeline plus a moving-platform FSM.
//   clock       : single clock, rising edge
//   reset       : synchronous, active-high
//   frame_start : one-cycle pulse advancing the platform FSM
//   pix         : pixel bus (slave) - pix_valid/x_cord/y_cord in, colour/colour_valid out
//   mov_x       : current left edge of the moving platform
// Optional feature: define SCENE_HELICOPTER_EN to add the helicopter sprite.
module scene_renderer #(
   parameter int unsigned SCREEN_W    = 320,
   parameter int unsigned SCREEN_H    = 240,
   parameter int unsigned COORD_W     = 9,
   parameter int unsigned MOV_Y       = 60,
   parameter int unsigned MOV_MIN     = 40,
   parameter int unsigned MOV_MAX     = 260,
   parameter int unsigned MOV_LEN     = 40,
   parameter int unsigned MOV_STEP    = 2,
   parameter int unsigned HOLD_FRAMES = 30
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               frame_start,
   scene_renderer_if.slave    pix,
   output logic [COORD_W-1:0] mov_x
);

   localparam int unsigned CW1       = COORD_W + 1;
   localparam int unsigned HW_RAW    = $clog2(HOLD_FRAMES + 1);
   localparam int unsigned HW        = (HW_RAW > 0) ? HW_RAW : 1;
   localparam int unsigned HOLD_LAST = (HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0;

   typedef enum logic [1:0] {
      MOVE_R = 2'd0,
      HOLD_R = 2'd1,
      MOVE_L = 2'd2,
      HOLD_L = 2'd3
   } state_t;

   state_t          state;
   logic [HW-1:0]   hold_cnt;

   // Coordinates widened by one bit so bound sums cannot wrap
   logic [CW1-1:0]  x_e, y_e, mx_e;
   assign x_e  = CW1'(pix.x_cord);
   assign y_e  = CW1'(pix.y_cord);
   assign mx_e = CW1'(mov_x);

   // Inclusive rectangle test
   function automatic logic in_rect(input logic [CW1-1:0] x, input logic [CW1-1:0] y,
                                    input int unsigned x0, input int unsigned x1,
                                    input int unsigned y0, input int unsigned y1);
      return (x >= CW1'(x0)) && (x <= CW1'(x1)) && (y >= CW1'(y0)) && (y <= CW1'(y1));
   endfunction

   // Stage-1 hit decode (combinational)
   logic off_c, grass_c, mov_c, stat_c;
   always_comb begin
      off_c   = (x_e >= CW1'(SCREEN_W)) || (y_e >= CW1'(SCREEN_H));
      grass_c = (y_e >= CW1'(SCREEN_H - 4));
      mov_c   = (x_e >= mx_e) && (x_e <= mx_e + CW1'(MOV_LEN - 1)) &&
                (y_e >= CW1'(MOV_Y)) && (y_e <= CW1'(MOV_Y + 3));
      stat_c  = in_rect(x_e, y_e,  60,  99, 180, 183) ||
                in_rect(x_e, y_e, 220, 259, 180, 183) ||
                in_rect(x_e, y_e, 100, 139, 120, 123) ||
                in_rect(x_e, y_e, 180, 219, 120, 123) ||
                (x_e == '0) || (x_e == CW1'(SCREEN_W - 1)) || (y_e == '0) ||
                in_rect(x_e, y_e,   8,  33, 120, 239) ||
                in_rect(x_e, y_e,   5,  36, 115, 120);
   end

`ifdef SCENE_HELICOPTER_EN
   // Cabin sits inside the body and takes precedence over the 110 parts
   logic heli_cab_c, heli_body_c;
   always_comb begin
      heli_cab_c  = in_rect(x_e, y_e, 240, 260, 40, 50);
      heli_body_c = in_rect(x_e, y_e, 240, 260, 30, 50) ||
                    in_rect(x_e, y_e, 260, 275, 35, 45) ||
                    in_rect(x_e, y_e, 237, 269, 34, 37);
   end
   logic heli_cab_q, heli_body_q;
`endif

   logic v1_q, off_q, grass_q, mov_q, stat_q;

   // Stage 1: per-object hit flags
   always_ff @(posedge clock) begin
      if (reset) begin
         v1_q    <= 1'b0;
         off_q   <= 1'b0;
         grass_q <= 1'b0;
         mov_q   <= 1'b0;
         stat_q  <= 1'b0;
`ifdef SCENE_HELICOPTER_EN
         heli_cab_q  <= 1'b0;
         heli_body_q <= 1'b0;
`endif
      end else begin
         v1_q    <= pix.pix_valid;
         off_q   <= off_c;
         grass_q <= grass_c;
         mov_q   <= mov_c;
         stat_q  <= stat_c;
`ifdef SCENE_HELICOPTER_EN
         heli_cab_q  <= heli_cab_c;
         heli_body_q <= heli_body_c;
`endif
      end
   end

   // Stage 2: priority-encoded colour
   always_ff @(posedge clock) begin
      if (reset) begin
         pix.colour       <= 3'b000;
         pix.colour_valid <= 1'b0;
      end else begin
         pix.colour_valid <= v1_q;
         if (off_q)              pix.colour <= 3'b000;
         else if (grass_q)       pix.colour <= 3'b010;
`ifdef SCENE_HELICOPTER_EN
         else if (heli_cab_q)    pix.colour <= 3'b011;
         else if (heli_body_q)   pix.colour <= 3'b110;
`endif
         else if (mov_q)         pix.colour <= 3'b101;
         else if (stat_q)        pix.colour <= 3'b111;
         else                    pix.colour <= 3'b000;
      end
   end

   // Platform motion: advances only on frame_start; end-of-travel clamps to the limit
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= MOVE_R;
         mov_x    <= COORD_W'(MOV_MIN);
         hold_cnt <= '0;
      end else if (frame_start) begin
         case (state)
            MOVE_R: begin
               if (mx_e + CW1'(MOV_STEP) >= CW1'(MOV_MAX)) begin
                  mov_x    <= COORD_W'(MOV_MAX);
                  hold_cnt <= '0;
                  state    <= (HOLD_FRAMES == 0) ? MOVE_L : HOLD_R;
               end else begin
                  mov_x <= COORD_W'(mx_e + CW1'(MOV_STEP));
               end
            end
            HOLD_R: begin
               hold_cnt <= hold_cnt + HW'(1);
               if (hold_cnt == HW'(HOLD_LAST)) state <= MOVE_L;
            end
            MOVE_L: begin
               if (mx_e <= CW1'(MOV_MIN) + CW1'(MOV_STEP)) begin
                  mov_x    <= COORD_W'(MOV_MIN);
                  hold_cnt <= '0;
                  state    <= (HOLD_FRAMES == 0) ? MOVE_R : HOLD_L;
               end else begin
                  mov_x <= COORD_W'(mx_e - CW1'(MOV_STEP));
               end
            end
            HOLD_L: begin
               hold_cnt <= hold_cnt + HW'(1);
               if (hold_cnt == HW'(HOLD_LAST)) state <= MOVE_R;
            end
            default: state <= MOVE_R;
         endcase
      end
   end

endmodule

// File: tb/tb_scene_renderer.sv
// Directed bench for scene_renderer: pipeline latency, colour priority,
// platform motion, same-cycle frame/pixel ordering, mid-stream reset.
module tb_scene_renderer;

   logic       clock;
   logic       reset;
   logic       frame_start;
   logic [8:0] mov_x;
   int         checks;
   int         failures;

   scene_renderer_if #(.COORD_W(9)) pix_if ();

   scene_renderer dut (
      .clock       (clock),
      .reset       (reset),
      .frame_start (frame_start),
      .pix         (pix_if),
      .mov_x       (mov_x)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Send one pixel and check its colour two edges later
   task automatic pixel(input string tag, input int x, input int y, input logic [2:0] exp);
      pix_if.pix_valid = 1'b1;
      pix_if.x_cord    = 9'(x);
      pix_if.y_cord    = 9'(y);
      tick();
      pix_if.pix_valid = 1'b0;
      tick();
      check({tag, "_valid"}, 16'(pix_if.colour_valid), 16'd1);
      check(tag, 16'(pix_if.colour), 16'(exp));
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
      end
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      reset            = 1'b1;
      frame_start      = 1'b0;
      pix_if.pix_valid = 1'b0;
      pix_if.x_cord    = '0;
      pix_if.y_cord    = '0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_colour_valid", 16'(pix_if.colour_valid), 16'd0);
      check("rst_colour", 16'(pix_if.colour), 16'd0);
      check("rst_mov_x", 16'(mov_x), 16'd40);

      // Pipeline: exactly one valid cycle, two edges after the pixel
      tick();
      pix_if.pix_valid = 1'b1;
      pix_if.x_cord    = 9'd60;
      pix_if.y_cord    = 9'd181;
      tick();
      pix_if.pix_valid = 1'b0;
      check("pipe_stage1_not_yet", 16'(pix_if.colour_valid), 16'd0);
      tick();
      check("pipe_valid", 16'(pix_if.colour_valid), 16'd1);
      check("pipe_colour", 16'(pix_if.colour), 16'd7);
      tick();
      check("pipe_bubble", 16'(pix_if.colour_valid), 16'd0);

      // Priority and bounds
      pixel("grass_over_tower", 10, 238, 3'b010);
      pixel("offscreen_x", 320, 10, 3'b000);
      pixel("offscreen_y", 5, 240, 3'b000);
      pixel("grass_over_border", 0, 236, 3'b010);
      pixel("tower_top_of_grass", 10, 235, 3'b111);
      pixel("border_left", 0, 50, 3'b111);
      pixel("border_right", 319, 5, 3'b111);
      pixel("border_top", 150, 0, 3'b111);
      pixel("cap_corner", 5, 115, 3'b111);
      pixel("cap_outside", 4, 115, 3'b000);
      pixel("plat_edge_in", 99, 183, 3'b111);
      pixel("plat_edge_out", 100, 183, 3'b000);
      pixel("plat_below", 60, 184, 3'b000);
      pixel("mov_at_reset", 79, 63, 3'b101);
      pixel("mov_right_out", 80, 63, 3'b000);
      pixel("empty_sky", 160, 100, 3'b000);
`ifdef SCENE_HELICOPTER_EN
      pixel("heli_cabin", 250, 45, 3'b011);
      pixel("heli_rotor", 237, 34, 3'b110);
`else
      pixel("heli_cabin", 250, 45, 3'b000);
      pixel("heli_rotor", 237, 34, 3'b000);
`endif

      // Same-cycle frame_start and pixel use the pre-update position
      frame_start      = 1'b1;
      pix_if.pix_valid = 1'b1;
      pix_if.x_cord    = 9'd40;
      pix_if.y_cord    = 9'd61;
      tick();
      frame_start = 1'b0;
      check("same_cycle_mov_x", 16'(mov_x), 16'd42);
      tick();
      pix_if.pix_valid = 1'b0;
      check("same_cycle_old_pos", 16'(pix_if.colour), 16'd5);
      tick();
      check("next_cycle_valid", 16'(pix_if.colour_valid), 16'd1);
      check("next_cycle_new_pos", 16'(pix_if.colour), 16'd0);

      // Return to reset state, reset overriding frame_start
      reset       = 1'b1;
      frame_start = 1'b1;
      tick();
      reset       = 1'b0;
      frame_start = 1'b0;
      check("reset_over_frame", 16'(mov_x), 16'd40);

      // Motion to the right limit and hold
      pulses(109);
      check("move_r_before_clamp", 16'(mov_x), 16'd258);
      pulses(1);
      check("clamp_max", 16'(mov_x), 16'd260);
      pixel("mov_left_edge", 260, 60, 3'b101);
      pixel("mov_right_edge", 299, 63, 3'b101);
      pixel("mov_past_right", 300, 60, 3'b000);
      pixel("mov_before_left", 259, 60, 3'b000);
      pixel("mov_below", 260, 64, 3'b000);
      pulses(29);
      check("hold_r_29", 16'(mov_x), 16'd260);
      pulses(1);
      check("hold_r_30", 16'(mov_x), 16'd260);
      pulses(1);
      check("move_l_first", 16'(mov_x), 16'd258);
      pulses(108);
      check("move_l_near_min", 16'(mov_x), 16'd42);
      pulses(1);
      check("clamp_min", 16'(mov_x), 16'd40);
      pulses(30);
      check("hold_l_30", 16'(mov_x), 16'd40);
      pulses(1);
      check("move_r_again", 16'(mov_x), 16'd42);

      // Reset mid-stream discards in-flight pixels
      pulses(3);
      check("pre_reset_mov_x", 16'(mov_x), 16'd48);
      pix_if.pix_valid = 1'b1;
      pix_if.x_cord    = 9'd60;
      pix_if.y_cord    = 9'd181;
      tick();
      reset       = 1'b1;
      frame_start = 1'b1;
      pix_if.x_cord = 9'd10;
      pix_if.y_cord = 9'd238;
      tick();
      reset            = 1'b0;
      frame_start      = 1'b0;
      pix_if.pix_valid = 1'b0;
      check("midrst_valid_0", 16'(pix_if.colour_valid), 16'd0);
      check("midrst_mov_x", 16'(mov_x), 16'd40);
      tick();
      check("midrst_valid_1", 16'(pix_if.colour_valid), 16'd0);
      tick();
      check("midrst_valid_2", 16'(pix_if.colour_valid), 16'd0);
      pixel("after_reset", 60, 181, 3'b111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scene_renderer.md
SCENE_RENDERER -- requirements
Module: scene_renderer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320: visible width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 240: visible height in pixels.
REQ-003 SHALL have parameter COORD_W, default 9: width of each coordinate.
REQ-004 SHALL have parameter MOV_Y, default 60: top row of the moving platform.
REQ-005 SHALL have parameter MOV_MIN, default 40, and MOV_MAX, default 260: travel limits of the moving platform's left edge.
REQ-006 SHALL have parameter MOV_LEN, default 40: moving platform length; its thickness is fixed at 4 rows.
REQ-007 SHALL have parameter MOV_STEP, default 2: pixels moved per step.
REQ-008 SHALL have parameter HOLD_FRAMES, default 30: frames paused at each end of travel.
REQ-009 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-010 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-011 SHALL have port frame_start, input, 1 bit: one-cycle pulse that advances the platform state.
REQ-012 SHALL have port pix_valid, input, 1 bit: x_cord and y_cord are valid this cycle.
REQ-013 SHALL have ports x_cord and y_cord, input, COORD_W bits each: pixel coordinates.
REQ-014 SHALL have port colour, output, 3 bits: RGB colour of the pixel.
REQ-015 SHALL have port colour_valid, output, 1 bit: qualifies colour.
REQ-016 SHALL have port mov_x, output, COORD_W bits: current left edge of the moving platform.

Function
REQ-017 SHALL have a fixed 2-cycle latency: a pixel sampled with pix_valid at edge N produces colour and colour_valid=1 at edge N+2; bubbles propagate unchanged.
REQ-018 SHALL register stage 1 as per-object hit flags and stage 2 as the priority-encoded colour.
REQ-019 SHALL resolve colour in this priority order (highest first):
- out-of-screen, x>=SCREEN_W or y>=SCREEN_H: 000.
- grass, y>=SCREEN_H-4: 010.
- moving platform: 101.
- static platforms (four full 40x4 at (60,180),(220,180),(100,120),(180,120)), border (x==0, x==SCREEN_W-1, y==0) and tower (x 8..33, y 120..239; cap x 5..36, y 115..120): 111.
- otherwise: 000.
REQ-020 SHALL include all bounds in every rectangle test, with comparisons done at COORD_W+1 bits so that sums cannot wrap.
REQ-021 SHALL run the platform FSM with states MOVE_R, HOLD_R, MOVE_L and HOLD_L, evaluated only in cycles where frame_start=1.
REQ-022 SHALL in MOVE_R use mov_x += MOV_STEP; when mov_x+MOV_STEP>=MOV_MAX it SHALL instead set mov_x=MOV_MAX, clear hold_cnt and go to HOLD_R.
REQ-023 SHALL in HOLD_R increment hold_cnt and, when hold_cnt==HOLD_FRAMES-1, go to MOVE_L; HOLD_FRAMES=0 SHALL skip the hold state.
REQ-024 SHALL make MOVE_L and HOLD_L mirror REQ-022 and REQ-023, clamping to MOV_MIN and returning to MOVE_R.
REQ-025 SHALL, for frame_start and pix_valid in the same cycle, evaluate that pixel against the pre-update mov_x; the new position applies from the next cycle.
REQ-026 SHALL drive mov_x from the FSM register with no extra latency.

Reset
REQ-027 SHALL, with reset=1 at a clock edge, set state=MOVE_R, mov_x=MOV_MIN, hold_cnt=0, both pipeline valid bits=0, colour=000 and colour_valid=0.
REQ-028 SHALL, on reset mid-frame, discard in-flight pixels (no colour_valid pulses for them), and reset SHALL override frame_start.

Configuration
REQ-029 SHALL, with macro SCENE_HELICOPTER_EN defined, add the helicopter sprite at priority just above the moving platform: body x 240..260, y 30..50 in 110; cabin x 240..260, y 40..50 in 011; tail x 260..275, y 35..45 in 110; rotor x 237..269, y 34..37 in 110.
REQ-030 SHALL, without SCENE_HELICOPTER_EN, have no helicopter logic and leave those pixels to the lower priorities.

Verification
REQ-031 SHALL cover the pipeline: after reset, pixel (60,181) valid at cycle 5 -> colour=111, colour_valid=1 at cycle 7 only.
REQ-032 SHALL cover priority: pixel (10,238) -> 010 (grass above tower); pixel (320,10) -> 000 (off-screen).
REQ-033 SHALL cover motion: 110 frame_start pulses from reset -> mov_x=260 and HOLD_R; 30 more pulses -> MOVE_L; the next pulse -> mov_x=258.
REQ-034 SHALL cover the same-cycle case: frame_start together with pixel (40,61) at reset state -> colour=101; the same pixel one cycle later -> 000 because mov_x=42.
REQ-035 SHALL cover reset mid-stream: reset asserted for 1 cycle between two valid pixels -> neither earlier pixel produces colour_valid, and mov_x=40.
REQ-036 SHALL cover the configuration: pixel (250,45) -> 011 with SCENE_HELICOPTER_EN and 000 without it.
